// File: rtl/reg_file_dump.sv
// Parametrised register file: two bypassed async read ports, one sync write port,
// plus a snapshot-and-serialise dump engine. Optional macro: REG_FILE_ZERO_REG_EN.
module reg_file_dump #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          WE,
  input  logic [AW-1:0] WA,
  input  logic [DW-1:0] WD,
  input  logic [AW-1:0] RA_A,
  input  logic [AW-1:0] RA_B,
  output logic [DW-1:0] RD_A,
  output logic [DW-1:0] RD_B,
  input  logic          DumpReq,
  output logic          DumpBusy,
  output logic          DumpValid,
  output logic          DumpOut,
  output logic          DumpDone
);

  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1'b1);
  localparam logic [AW-1:0] IDX_LAST = AW'(NREG - 1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  logic [DW-1:0] regs_r   [NREG];
  logic [DW-1:0] shadow_r [NREG];
  logic [DW-1:0] snap_s   [NREG];
  logic          wr_en_s;
  state_t        state_r;
  logic [BW-1:0] bit_r;
  logic [AW-1:0] idx_r;
  logic [BW-1:0] nbit_s;
  logic [AW-1:0] nidx_s;

  // Effective write enable; register 0 may be hard-wired to zero
  always_comb begin
`ifdef REG_FILE_ZERO_REG_EN
    wr_en_s = WE && (WA != {AW{1'b0}});
`else
    wr_en_s = WE;
`endif
  end

  // Register array storage with synchronous clear
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) regs_r[i] <= {DW{1'b0}};
    end else if (wr_en_s) begin
      regs_r[WA] <= WD;
    end
  end

  // Read ports and dump snapshot, both seeing the same-edge write
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      if (wr_en_s && (WA == AW'(i))) snap_s[i] = WD;
      else                           snap_s[i] = regs_r[i];
    end
`ifdef REG_FILE_ZERO_REG_EN
    snap_s[0] = {DW{1'b0}};
`endif
    RD_A = snap_s[RA_A];
    RD_B = snap_s[RA_B];
  end

  // Next serial position within the shadow array
  always_comb begin
    if (bit_r == BIT_LAST) begin
      nbit_s = {BW{1'b0}};
      nidx_s = idx_r + IDX_ONE;
    end else begin
      nbit_s = bit_r + BIT_ONE;
      nidx_s = idx_r;
    end
  end

  // Dump FSM with registered serial outputs
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r   <= ST_IDLE;
      bit_r     <= {BW{1'b0}};
      idx_r     <= {AW{1'b0}};
      DumpBusy  <= 1'b0;
      DumpValid <= 1'b0;
      DumpOut   <= 1'b0;
      DumpDone  <= 1'b0;
      for (int i = 0; i < NREG; i++) shadow_r[i] <= {DW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          DumpDone <= 1'b0;
          if (DumpReq) begin
            for (int i = 0; i < NREG; i++) shadow_r[i] <= snap_s[i];
            bit_r     <= {BW{1'b0}};
            idx_r     <= {AW{1'b0}};
            state_r   <= ST_SHIFT;
            DumpBusy  <= 1'b1;
            DumpValid <= 1'b1;
            DumpOut   <= snap_s[0][DW-1];
          end else begin
            DumpBusy  <= 1'b0;
            DumpValid <= 1'b0;
            DumpOut   <= 1'b0;
          end
        end
        ST_SHIFT: begin
          DumpBusy <= 1'b1;
          if ((idx_r == IDX_LAST) && (bit_r == BIT_LAST)) begin
            state_r   <= ST_DONE;
            DumpValid <= 1'b0;
            DumpOut   <= 1'b0;
            DumpDone  <= 1'b1;
          end else begin
            bit_r     <= nbit_s;
            idx_r     <= nidx_s;
            DumpValid <= 1'b1;
            DumpOut   <= shadow_r[nidx_s][BIT_LAST - nbit_s];
            DumpDone  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r   <= ST_IDLE;
          DumpBusy  <= 1'b0;
          DumpValid <= 1'b0;
          DumpOut   <= 1'b0;
          DumpDone  <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          DumpBusy  <= 1'b0;
          DumpValid <= 1'b0;
          DumpOut   <= 1'b0;
          DumpDone  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_dump.sv
// Self-checking bench for reg_file_dump: vector table, dump corner sequences and
// randomized traffic against a queue-based reference model.
module tb_reg_file_dump;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam logic [127:0] EXP_STREAM = {16'h0000, 16'h1111, 16'h2222, 16'h3333,
                                         16'h4444, 16'h5555, 16'h6666, 16'h7777};
`ifdef REG_FILE_ZERO_REG_EN
  localparam logic [15:0] ZA = 16'h0000;
`else
  localparam logic [15:0] ZA = 16'hABCD;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          we = 1'b0;
  logic [AW-1:0] wa = 3'd0;
  logic [DW-1:0] wd = 16'h0000;
  logic [AW-1:0] ra_a = 3'd0;
  logic [AW-1:0] ra_b = 3'd0;
  logic          dump_req = 1'b0;
  logic [DW-1:0] rd_a, rd_b;
  logic          dump_busy, dump_valid, dump_out, dump_done;

  reg_file_dump #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
    .CLK(clk), .Reset(reset), .WE(we), .WA(wa), .WD(wd),
    .RA_A(ra_a), .RA_B(ra_b), .RD_A(rd_a), .RD_B(rd_b),
    .DumpReq(dump_req), .DumpBusy(dump_busy), .DumpValid(dump_valid),
    .DumpOut(dump_out), .DumpDone(dump_done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: register contents plus a queue of expected per-cycle outputs
  typedef struct packed {logic busy; logic valid; logic out; logic done;} dout_t;
  logic [DW-1:0] m_regs [NREG];
  dout_t         m_q[$];
  dout_t         m_cur = 4'b0000;

  function automatic logic zero_reg(input logic [AW-1:0] a);
`ifdef REG_FILE_ZERO_REG_EN
    return a == 3'd0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] ra);
    if (zero_reg(ra)) return 16'h0000;
    if (we && wa == ra) return wd;
    return m_regs[ra];
  endfunction

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < NREG; i++) m_regs[i] = 16'h0000;
      m_q.delete();
      m_cur = 4'b0000;
    end else begin
      if (we && !zero_reg(wa)) m_regs[wa] = wd;
      if (!m_cur.busy && dump_req) begin
        for (int r = 0; r < NREG; r++)
          for (int b = DW - 1; b >= 0; b--)
            m_q.push_back({1'b1, 1'b1, m_regs[r][b], 1'b0});
        m_q.push_back(4'b1001);
      end
      if (m_q.size() > 0) m_cur = m_q.pop_front();
      else m_cur = 4'b0000;
    end
  endtask

  task automatic step(input bit do_rd);
    #1;
    if (do_rd) begin
      chk("rd_a_model", rd_a, model_rd(ra_a));
      chk("rd_b_model", rd_b, model_rd(ra_b));
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("dump_outputs", {dump_busy, dump_valid, dump_out, dump_done}, m_cur);
  endtask

  task automatic drive_check(input logic [15:0] exp_a, input logic [15:0] exp_b);
    #1;
    chk("rd_a_vec", rd_a, exp_a);
    chk("rd_b_vec", rd_b, exp_b);
    step(1'b1);
  endtask

  typedef struct {
    logic we; logic [2:0] wa; logic [15:0] wd;
    logic [2:0] ra_a; logic [2:0] ra_b;
    logic [15:0] exp_a; logic [15:0] exp_b;
  } vec_t;
  vec_t vecs[7];

  logic [127:0] stream;
  int n_valid, n_done, done_at;

  initial begin
    vecs[0] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd7, 16'h5555, 16'h7777};
    vecs[1] = '{1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3, 16'hBEEF, 16'hBEEF};
    vecs[2] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd0, 16'hBEEF, 16'h0000};
    vecs[3] = '{1'b1, 3'd0, 16'hABCD, 3'd0, 3'd1, ZA,       16'h1111};
    vecs[4] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd6, ZA,       16'h6666};
    vecs[5] = '{1'b1, 3'd3, 16'h3333, 3'd2, 3'd3, 16'h2222, 16'h3333};
    vecs[6] = '{1'b1, 3'd0, 16'h0000, 3'd0, 3'd0, 16'h0000, 16'h0000};

    // Reset for three cycles, then every address reads zero on both ports
    for (int k = 0; k < 3; k++) step(1'b0);
    reset = 1'b0;
    for (int a = 0; a < NREG; a++) begin
      ra_a = 3'(a);
      ra_b = 3'(NREG - 1 - a);
      drive_check(16'h0000, 16'h0000);
    end

    // Load regs[i] = 0x1111*i
    for (int i = 0; i < NREG; i++) begin
      we = 1'b1; wa = 3'(i); wd = 16'(16'h1111 * i);
      step(1'b1);
    end
    we = 1'b0;

    for (int v = 0; v < 7; v++) begin
      we = vecs[v].we; wa = vecs[v].wa; wd = vecs[v].wd;
      ra_a = vecs[v].ra_a; ra_b = vecs[v].ra_b;
      drive_check(vecs[v].exp_a, vecs[v].exp_b);
    end
    we = 1'b0;

    // Full dump with a mid-dump write and an ignored second request
    stream = 128'd0; n_valid = 0; n_done = 0; done_at = 0;
    for (int k = 1; k <= 140; k++) begin
      dump_req = (k == 1 || k == 51);
      we = (k == 12); wa = 3'd7; wd = 16'hFFFF;
      step(1'b1);
      if (dump_valid) begin
        stream = {stream[126:0], dump_out};
        n_valid++;
      end
      if (dump_done) begin
        n_done++;
        done_at = k;
      end
    end
    we = 1'b0; dump_req = 1'b0;
    chk("dump_stream_hi", stream[127:96], EXP_STREAM[127:96]);
    chk("dump_stream_lo", stream[31:0], EXP_STREAM[31:0]);
    chk("dump_stream_mid", stream[95:32] == EXP_STREAM[95:32], 32'd1);
    chk("valid_count", n_valid, 32'd128);
    chk("done_count", n_done, 32'd1);
    chk("done_cycle", done_at, 32'd129);
    ra_a = 3'd7; ra_b = 3'd6;
    drive_check(16'hFFFF, 16'h6666);

    // Reset at SHIFT cycle 40 aborts the dump and clears the registers
    n_done = 0;
    for (int k = 1; k <= 41; k++) begin
      dump_req = (k == 1);
      reset = (k == 41);
      step(1'b1);
    end
    chk("abort_busy", dump_busy, 32'd0);
    chk("abort_valid", dump_valid, 32'd0);
    chk("abort_done", dump_done, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 140; k++) begin
      step(1'b1);
      if (dump_done) n_done++;
    end
    chk("abort_no_done", n_done, 32'd0);
    for (int a = 0; a < NREG; a++) begin
      ra_a = 3'(a); ra_b = 3'(a);
      drive_check(16'h0000, 16'h0000);
    end

    // DumpReq held high re-triggers on the first IDLE cycle after DONE
    for (int k = 1; k <= 135; k++) begin
      dump_req = 1'b1;
      step(1'b1);
      if (k == 129) chk("held_done", dump_done, 32'd1);
      if (k == 130) chk("held_gap_valid", dump_valid, 32'd0);
      if (k == 131) chk("held_retrigger", dump_valid, 32'd1);
    end
    dump_req = 1'b0;
    for (int k = 0; k < 140; k++) step(1'b1);

    // Randomized traffic against the model
    for (int k = 0; k < 2000; k++) begin
      reset    = ($urandom_range(0, 299) == 0);
      we       = 1'($urandom_range(0, 1));
      wa       = 3'($urandom_range(0, NREG - 1));
      wd       = 16'($urandom);
      ra_a     = 3'($urandom_range(0, NREG - 1));
      ra_b     = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, NREG - 1));
      dump_req = ($urandom_range(0, 29) == 0);
      step(1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
